pwm_multi: RTL and testbench
============================

PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL provide parameter R, default 10, counter resolution in bits.
REQ-002 SHALL provide parameter N, default 4, number of PWM channels.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_en  input  1  run enable.
REQ-006 SHALL have port i_dvsr  input  32  prescale divisor; tick period = i_dvsr+1 cycles.
REQ-007 SHALL have port i_duty  input  N*(R+1)  packed duties; channel k at bits [k*(R+1) +: R+1].
REQ-008 SHALL have port i_load  input  1  request to capture i_duty into shadow.
REQ-009 SHALL have port o_busy  output  1  shadow holds a pending, unapplied duty set.
REQ-010 SHALL have port o_period_end  output  1  one-cycle pulse at each period boundary.
REQ-011 SHALL have port o_pwm  output  N  registered PWM outputs.

Function
REQ-012 Prescaler q (32b) SHALL, when i_en=1, load 0 if q>=i_dvsr, else q+1; tick SHALL be q==0 && i_en.
REQ-013 Period counter d (R bits) SHALL advance only on tick; edge mode: increments, 2^R-1 wraps to 0.
REQ-014 Boundary SHALL be the tick on which d returns to 0; o_period_end SHALL pulse in the following cycle.
REQ-015 Each o_pwm[k] SHALL equal the registered value of ({1'b0,d} < duty_act[k]), one cycle after d changes.
REQ-016 duty_act[k]=0 SHALL give constant low; duty_act[k]>=2^R SHALL give constant high.
REQ-017 i_load=1 with o_busy=0 SHALL capture i_duty into shadow and set o_busy next cycle.
REQ-018 i_load=1 with o_busy=1 SHALL be ignored; shadow unchanged.
REQ-019 At the boundary, shadow SHALL copy into duty_act and o_busy SHALL clear in the same cycle.
REQ-020 i_load accepted on the boundary cycle with o_busy=0 SHALL be applied at the next boundary, not this one.
REQ-021 i_en=0 SHALL force q=0, d=0 and o_pwm=0; a pending shadow SHALL apply immediately and o_busy clear.
REQ-022 Change of i_dvsr mid-count SHALL take effect on the current prescale count with no lock-up (REQ-012 >= rule).

Reset
REQ-023 i_rst_n=0 at a clock edge SHALL clear q, d, shadow, duty_act, direction (up), mode; o_pwm=0, o_busy=0, o_period_end=0.
REQ-024 Reset mid-period SHALL discard any pending shadow; first tick after release occurs on the first enabled cycle.

Configuration
REQ-025 Macro PWM_MULTI_CENTER_EN SHALL, when defined, add port i_center (input, 1) selecting center-aligned mode.
REQ-026 With macro: i_center SHALL be latched into mode only at a boundary or while i_en=0.
REQ-027 With macro, center mode: d SHALL count 0..2^R-1 then 2^R-2..1, reversing direction; period 2^(R+1)-2 ticks; boundary when d goes 1->0 counting down.
REQ-028 Without macro: no i_center port, edge-aligned only, logic identical to mode=0.

Verification
REQ-029 R=4,N=2,dvsr=0,duty0=8 loaded then i_en=1 -> after first boundary o_pwm[0] 8 high / 8 low per 16 cycles, o_period_end every 16 cycles.
REQ-030 duty0=0, duty1=16 -> o_pwm[0] constantly 0, o_pwm[1] constantly 1 after apply.
REQ-031 dvsr=2, duty0=4 -> tick every 3 cycles, period 48 cycles, 12 high cycles.
REQ-032 load duty=12 mid-period, then load duty=2 while o_busy=1 -> 12 applied at next boundary, 2 ignored, o_busy high until boundary.
REQ-033 i_rst_n=0 for 1 cycle mid-period with o_busy=1 -> all outputs 0, o_busy 0, old duty lost.
REQ-034 Macro defined, R=4, dvsr=0, duty=4, i_center=1 -> period 30 cycles, single contiguous 7-cycle high pulse centred on d=0.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared prescaler, a period counter and double-buffered duties.
// Define PWM_MULTI_CENTER_EN to add the i_center port and the center-aligned (up/down) mode.
module pwm_multi #(
    parameter int R = 10,
    parameter int N = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [31:0]        i_dvsr,
    input  logic [N*(R+1)-1:0] i_duty,
    input  logic               i_load,
`ifdef PWM_MULTI_CENTER_EN
    input  logic               i_center,
`endif
    output logic               o_busy,
    output logic               o_period_end,
    output logic [N-1:0]       o_pwm
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam logic [R-1:0] D_MAX = '1;
    localparam logic [R-1:0] D_ONE = {{(R-1){1'b0}}, 1'b1};

    logic [31:0]        q;
    logic [R-1:0]       d;
    logic [R-1:0]       d_next;
    dir_t               dir;
    dir_t               dir_next;
    logic               mode;
    logic               tick;
    logic               boundary;
    logic [N-1:0]       pwm_cmp;
    logic [N*(R+1)-1:0] shadow;
    logic [N*(R+1)-1:0] duty_act;

    assign tick = (q == 32'd0) && i_en;

    // Next count; in center mode a stray d==0 while counting down is treated as a boundary so it cannot wrap.
    always_comb begin
        d_next   = d;
        dir_next = dir;
        boundary = 1'b0;
        if (tick) begin
            if (mode) begin
                if (dir == DIR_UP) begin
                    if (d == D_MAX) begin
                        d_next   = d - D_ONE;
                        dir_next = DIR_DOWN;
                    end else begin
                        d_next = d + D_ONE;
                    end
                end else if (d <= D_ONE) begin
                    d_next   = '0;
                    dir_next = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    d_next = d - D_ONE;
                end
            end else begin
                d_next   = d + D_ONE;
                boundary = (d == D_MAX);
            end
        end
    end

    always_comb begin
        pwm_cmp = '0;
        for (int k = 0; k < N; k++) begin
            pwm_cmp[k] = ({1'b0, d} < duty_act[k*(R+1) +: (R+1)]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_en) begin
            q            <= 32'd0;
            d            <= '0;
            dir          <= DIR_UP;
            o_period_end <= 1'b0;
            o_pwm        <= '0;
        end else begin
            q            <= (q >= i_dvsr) ? 32'd0 : q + 32'd1;
            d            <= d_next;
            dir          <= dir_next;
            o_period_end <= boundary;
            o_pwm        <= pwm_cmp;
        end
    end

    // A pending shadow is applied at a boundary, or at once while the counter is stopped.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            shadow   <= '0;
            duty_act <= '0;
            o_busy   <= 1'b0;
        end else if (o_busy && (boundary || !i_en)) begin
            duty_act <= shadow;
            o_busy   <= 1'b0;
        end else if (i_load && !o_busy) begin
            shadow <= i_duty;
            o_busy <= 1'b1;
        end
    end

`ifdef PWM_MULTI_CENTER_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mode <= 1'b0;
        end else if (!i_en || boundary) begin
            mode <= i_center;
        end
    end
`else
    assign mode = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi (R=4, N=2): per-period expectations are queued by the stimulus
// and compared by a monitor at every o_period_end pulse; covers center mode when PWM_MULTI_CENTER_EN is defined.
module tb_pwm_multi;

    localparam int R = 4;
    localparam int N = 2;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic               i_en;
    logic [31:0]        i_dvsr;
    logic [N*(R+1)-1:0] i_duty;
    logic               i_load;
    logic               i_center;
    logic               o_busy;
    logic               o_period_end;
    logic [N-1:0]       o_pwm;

    typedef struct {
        int len;
        int hi0;
        int hi1;
        int rise0;
        int rise1;
    } window_t;

    window_t exp_q[$];

    int checks     = 0;
    int errors     = 0;
    int period_cnt = 0;

    int           win_len   = 0;
    int           win_hi0   = 0;
    int           win_hi1   = 0;
    int           win_rise0 = 0;
    int           win_rise1 = 0;
    logic [N-1:0] prev_pwm  = '0;

    pwm_multi #(.R(R), .N(N)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .i_dvsr       (i_dvsr),
        .i_duty       (i_duty),
        .i_load       (i_load),
`ifdef PWM_MULTI_CENTER_EN
        .i_center     (i_center),
`endif
        .o_busy       (o_busy),
        .o_period_end (o_period_end),
        .o_pwm        (o_pwm)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pulses i_load for exactly one rising edge with the two channel duties packed.
    task automatic applyStimulus(input int d0, input int d1);
        logic [R:0] v0;
        logic [R:0] v1;
        v0     = d0[R:0];
        v1     = d1[R:0];
        i_duty = {v1, v0};
        i_load = 1'b1;
        @(negedge i_clk);
        #1;
        i_load = 1'b0;
    endtask

    task automatic pushExpect(input int len, input int h0, input int h1, input int r0, input int r1);
        window_t w;
        w.len   = len;
        w.hi0   = h0;
        w.hi1   = h1;
        w.rise0 = r0;
        w.rise1 = r1;
        exp_q.push_back(w);
    endtask

    task automatic waitPeriods(input int n);
        int target;
        int cycles;
        target = period_cnt + n;
        cycles = 0;
        while (period_cnt < target && cycles < 100 * n) begin
            @(negedge i_clk);
            #1;
            cycles++;
        end
        checkOutput("period_wait_timeout", int'(period_cnt < target), 0);
    endtask

    // Monitor: accumulates one PWM period and scores it against the oldest queued expectation.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            win_len++;
            win_hi0 += int'(o_pwm[0]);
            win_hi1 += int'(o_pwm[1]);
            if (o_pwm[0] && !prev_pwm[0]) win_rise0++;
            if (o_pwm[1] && !prev_pwm[1]) win_rise1++;
            prev_pwm = o_pwm;
            if (o_period_end) begin
                if (exp_q.size() > 0) begin
                    window_t e;
                    e = exp_q.pop_front();
                    checkOutput("period_len", win_len, e.len);
                    checkOutput("high_cycles_ch0", win_hi0, e.hi0);
                    checkOutput("high_cycles_ch1", win_hi1, e.hi1);
                    checkOutput("rising_edges_ch0", win_rise0, e.rise0);
                    checkOutput("rising_edges_ch1", win_rise1, e.rise1);
                end
                win_len   = 0;
                win_hi0   = 0;
                win_hi1   = 0;
                win_rise0 = 0;
                win_rise1 = 0;
                period_cnt++;
            end
        end
    end

    initial begin
        int cnt;
        i_rst_n  = 1'b0;
        i_en     = 1'b0;
        i_dvsr   = 32'd0;
        i_duty   = '0;
        i_load   = 1'b0;
        i_center = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        checkOutput("reset_pwm", int'(o_pwm), 0);
        checkOutput("reset_busy", int'(o_busy), 0);
        checkOutput("reset_period_end", int'(o_period_end), 0);
        i_rst_n = 1'b1;

        // Load while stopped: shadow applies immediately, outputs stay low.
        applyStimulus(8, 16);
        checkOutput("busy_after_load", int'(o_busy), 1);
        @(negedge i_clk);
        #1;
        checkOutput("busy_cleared_while_disabled", int'(o_busy), 0);
        checkOutput("pwm_low_while_disabled", int'(o_pwm), 0);

        $display("[TB] edge mode, dvsr=0, duty 8/16");
        i_en = 1'b1;
        waitPeriods(1);
        pushExpect(16, 8, 16, 1, 0);
        pushExpect(16, 8, 16, 1, 0);
        waitPeriods(2);

        $display("[TB] duty 0/16 constant outputs");
        applyStimulus(0, 16);
        checkOutput("busy_mid_period", int'(o_busy), 1);
        waitPeriods(1);
        checkOutput("busy_after_apply", int'(o_busy), 0);
        pushExpect(16, 0, 16, 0, 0);
        waitPeriods(1);

        $display("[TB] dvsr=2, duty 4");
        i_dvsr = 32'd2;
        applyStimulus(4, 0);
        waitPeriods(1);
        pushExpect(48, 12, 0, 1, 0);
        waitPeriods(1);

        $display("[TB] load while busy is ignored");
        i_dvsr = 32'd0;
        waitPeriods(1);
        applyStimulus(12, 0);
        checkOutput("busy_first_load", int'(o_busy), 1);
        applyStimulus(2, 0);
        checkOutput("busy_second_load", int'(o_busy), 1);
        waitPeriods(1);
        checkOutput("busy_at_boundary", int'(o_busy), 0);
        pushExpect(16, 12, 0, 1, 0);
        pushExpect(16, 12, 0, 1, 0);
        waitPeriods(2);

        $display("[TB] reset mid-period with pending shadow");
        applyStimulus(5, 3);
        checkOutput("busy_before_reset", int'(o_busy), 1);
        repeat (3) @(negedge i_clk);
        #1;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        #1;
        checkOutput("midreset_pwm", int'(o_pwm), 0);
        checkOutput("midreset_busy", int'(o_busy), 0);
        checkOutput("midreset_period_end", int'(o_period_end), 0);
        i_rst_n = 1'b1;
        cnt = 0;
        do begin
            @(negedge i_clk);
            #1;
            cnt++;
        end while (!o_period_end && cnt < 100);
        checkOutput("cycles_to_first_period_end", cnt, 16);
        checkOutput("busy_after_reset", int'(o_busy), 0);
        pushExpect(16, 0, 0, 0, 0);
        waitPeriods(1);

`ifdef PWM_MULTI_CENTER_EN
        $display("[TB] center mode, duty 4");
        i_center = 1'b1;
        applyStimulus(4, 0);
        waitPeriods(2);
        pushExpect(30, 7, 0, 1, 0);
        pushExpect(30, 7, 0, 1, 0);
        waitPeriods(2);
`endif

        checkOutput("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
